approx_mac_accumulator: RTL and testbench



---
 rtl/approx_mac_pkg.sv | 14 +
 rtl/approx_mac_accumulator_if.sv | 26 ++
 rtl/approx_mac_addsat.sv | 22 ++
 rtl/approx_mac_accumulator.sv | 128 ++++++++++++
 tb/tb_approx_mac_accumulator.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/approx_mac_pkg.sv
// Shared types and default constants for the approximate MAC datapath stages.
package approx_mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int ACC_W_DEF   = 24;
    localparam int MAX_LEN_DEF = 256;
    localparam int PROD_W      = 16;

endpackage

// File: rtl/approx_mac_accumulator_if.sv
// Product-in / result-out handshake bundle for approx_mac_accumulator.
interface approx_mac_accumulator_if #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 9
) ();
    logic             prod_valid;
    logic             prod_ready;
    logic [15:0]      prod_data;
    logic             prod_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_trunc;
    logic             out_ovf;

    modport master (
        output prod_valid, prod_data, prod_last, out_ready,
        input  prod_ready, out_valid, out_sum, out_count, out_trunc, out_ovf
    );

    modport slave (
        input  prod_valid, prod_data, prod_last, out_ready,
        output prod_ready, out_valid, out_sum, out_count, out_trunc, out_ovf
    );
endinterface

// File: rtl/approx_mac_addsat.sv
// Combinational ACC_W-bit adder with carry-out; clamps to all-ones on carry
// when APPROX_MAC_SATURATE_EN is defined, otherwise wraps.
module approx_mac_addsat #(
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);
    logic [ACC_W:0] full_sum;

    assign full_sum = {1'b0, a} + {1'b0, b};
    assign carry    = full_sum[ACC_W];

`ifdef APPROX_MAC_SATURATE_EN
    assign sum = carry ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
    assign sum = full_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/approx_mac_accumulator.sv
// Frame accumulator for the approximate multiplier product stream.
// Optional clamp-on-overflow via APPROX_MAC_SATURATE_EN (see approx_mac_addsat).
module approx_mac_accumulator
    import approx_mac_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    approx_mac_accumulator_if.slave bus
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trunc_q, trunc_d;
    logic             ovf_q, ovf_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;

    logic             accept;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] add_a;
    logic [ACC_W-1:0] add_sum;
    logic             add_carry;
    logic [CNT_W-1:0] cnt_inc;

    assign accept   = bus.prod_valid & ready_q;
    assign prod_ext = ACC_W'(bus.prod_data);
    // The first beat of a frame starts from zero rather than the stale sum.
    assign add_a    = (state_q == IDLE) ? '0 : acc_q;
    assign cnt_inc  = cnt_q + ONE_CNT;

    approx_mac_addsat #(.ACC_W(ACC_W)) u_addsat (
        .a     (add_a),
        .b     (prod_ext),
        .sum   (add_sum),
        .carry (add_carry)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        trunc_d = trunc_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                acc_d   = '0;
                cnt_d   = '0;
                trunc_d = 1'b0;
                ovf_d   = 1'b0;
                if (accept) begin
                    acc_d = add_sum;
                    cnt_d = ONE_CNT;
                    if (bus.prod_last) begin
                        state_d = HOLD;
                    end else if (MAX_CNT == ONE_CNT) begin
                        state_d = HOLD;
                        trunc_d = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = add_sum;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | add_carry;
                    // A last flag on the MAX_LEN-th beat is a normal close.
                    if (bus.prod_last) begin
                        state_d = HOLD;
                    end else if (cnt_inc == MAX_CNT) begin
                        state_d = HOLD;
                        trunc_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    trunc_d = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d != HOLD);
        valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            trunc_q <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign bus.prod_ready = ready_q;
    assign bus.out_valid  = valid_q;
    assign bus.out_sum    = acc_q;
    assign bus.out_count  = cnt_q;
    assign bus.out_trunc  = trunc_q;
    assign bus.out_ovf    = ovf_q;

endmodule

// File: tb/tb_approx_mac_accumulator.sv
// Directed self-checking bench: a default 24-bit instance plus a 17-bit
// instance used for the overflow scenarios.
module tb_approx_mac_accumulator;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    approx_mac_accumulator_if #(.ACC_W(24), .CNT_W(9)) b1 ();
    approx_mac_accumulator_if #(.ACC_W(17), .CNT_W(9)) b2 ();

    approx_mac_accumulator #(.ACC_W(24), .MAX_LEN(256), .CNT_W(9)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.slave)
    );

    approx_mac_accumulator #(.ACC_W(17), .MAX_LEN(256), .CNT_W(9)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one beat on dut1 starting at a negedge; returns at the negedge
    // after the posedge that accepted it.
    task automatic send_beat(input logic [15:0] d, input logic l);
        int n;
        n = 0;
        b1.prod_valid = 1'b1;
        b1.prod_data  = d;
        b1.prod_last  = l;
        while (b1.prod_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            bad++;
            $display("FAIL send_beat_timeout: prod_ready=%b required=1", b1.prod_ready);
        end
        total++;
        @(negedge clk);
        b1.prod_valid = 1'b0;
        b1.prod_last  = 1'b0;
        b1.prod_data  = 16'h0;
    endtask

    task automatic send_beat2(input logic [15:0] d, input logic l);
        int n;
        n = 0;
        b2.prod_valid = 1'b1;
        b2.prod_data  = d;
        b2.prod_last  = l;
        while (b2.prod_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            bad++;
            $display("FAIL send_beat2_timeout: prod_ready=%b required=1", b2.prod_ready);
        end
        total++;
        @(negedge clk);
        b2.prod_valid = 1'b0;
        b2.prod_last  = 1'b0;
        b2.prod_data  = 16'h0;
    endtask

    // Wait (bounded) for a dut1 result, capture it, then complete the handshake.
    task automatic collect1(output logic got, output logic [23:0] s, output logic [8:0] c,
                            output logic t, output logic o);
        int n;
        n = 0;
        while (b1.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        got = b1.out_valid;
        s   = b1.out_sum;
        c   = b1.out_count;
        t   = b1.out_trunc;
        o   = b1.out_ovf;
        b1.out_ready = 1'b1;
        @(negedge clk);
        b1.out_ready = 1'b0;
    endtask

    task automatic collect2(output logic got, output logic [16:0] s, output logic [8:0] c,
                            output logic t, output logic o);
        int n;
        n = 0;
        while (b2.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        got = b2.out_valid;
        s   = b2.out_sum;
        c   = b2.out_count;
        t   = b2.out_trunc;
        o   = b2.out_ovf;
        b2.out_ready = 1'b1;
        @(negedge clk);
        b2.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic got, t, o;
        logic [23:0] s;
        logic [8:0]  c;
        @(negedge clk);
        total++;
        if ({b1.prod_ready, b1.out_valid, b1.out_sum, b1.out_count, b1.out_trunc, b1.out_ovf} !== 37'h0) begin
            bad++;
            $display("FAIL reset_values: ready=%b valid=%b sum=%0d cnt=%0d trunc=%b ovf=%b required all 0",
                     b1.prod_ready, b1.out_valid, b1.out_sum, b1.out_count, b1.out_trunc, b1.out_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (b1.prod_ready !== 1'b1 || b1.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: ready=%b valid=%b required ready=1 valid=0",
                     b1.prod_ready, b1.out_valid);
        end
        send_beat(16'd1, 1'b0);
        send_beat(16'd2, 1'b0);
        send_beat(16'd3, 1'b0);
        rst_n = 1'b0;
        #2;
        total++;
        if (b1.prod_ready !== 1'b0 || b1.out_count !== 9'd0 || b1.out_sum !== 24'd0) begin
            bad++;
            $display("FAIL async_reset_midframe: ready=%b cnt=%0d sum=%0d required 0/0/0",
                     b1.prod_ready, b1.out_count, b1.out_sum);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_beat(16'h0005, 1'b1);
        collect1(got, s, c, t, o);
        total++;
        if ({got, s, c, t, o} !== {1'b1, 24'd5, 9'd1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_then_single: valid=%b sum=%0d cnt=%0d trunc=%b ovf=%b required 1/5/1/0/0",
                     got, s, c, t, o);
        end
        $display("reset scenario: sum=%0d cnt=%0d", s, c);
    endtask

    task automatic test_normal_frame();
        b1.out_ready = 1'b1;
        send_beat(16'd100, 1'b0);
        send_beat(16'd200, 1'b0);
        b1.out_ready = 1'b0;
        send_beat(16'd300, 1'b1);
        total++;
        if (b1.out_valid !== 1'b1 || b1.prod_ready !== 1'b0 || b1.out_sum !== 24'd600 ||
            b1.out_count !== 9'd3) begin
            bad++;
            $display("FAIL normal_result: valid=%b ready=%b sum=%0d cnt=%0d required 1/0/600/3",
                     b1.out_valid, b1.prod_ready, b1.out_sum, b1.out_count);
        end
        b1.out_ready = 1'b1;
        @(negedge clk);
        b1.out_ready = 1'b0;
        total++;
        if (b1.out_valid !== 1'b0 || b1.prod_ready !== 1'b1) begin
            bad++;
            $display("FAIL normal_bubble: valid=%b ready=%b required 0/1", b1.out_valid, b1.prod_ready);
        end
        $display("normal frame: sum=600 cnt=3 checked");
    endtask

    task automatic test_backpressure();
        b1.out_ready = 1'b0;
        send_beat(16'd100, 1'b0);
        send_beat(16'd200, 1'b0);
        send_beat(16'd300, 1'b1);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (b1.out_valid !== 1'b1 || b1.out_sum !== 24'd600 || b1.prod_ready !== 1'b0) begin
                bad++;
                $display("FAIL backpressure_hold[%0d]: valid=%b sum=%0d ready=%b required 1/600/0",
                         i, b1.out_valid, b1.out_sum, b1.prod_ready);
            end
            @(negedge clk);
        end
        b1.out_ready = 1'b1;
        @(negedge clk);
        b1.out_ready = 1'b0;
        total++;
        if (b1.out_valid !== 1'b0 || b1.prod_ready !== 1'b1) begin
            bad++;
            $display("FAIL backpressure_release: valid=%b ready=%b required 0/1",
                     b1.out_valid, b1.prod_ready);
        end
        $display("backpressure: 5 stalled cycles checked");
    endtask

    task automatic test_forced_close();
        logic got, t, o;
        logic [23:0] s;
        logic [8:0]  c;
        for (int i = 0; i < 256; i++) send_beat(16'h0001, 1'b0);
        collect1(got, s, c, t, o);
        total++;
        if ({got, s, c, t, o} !== {1'b1, 24'd256, 9'd256, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL forced_close: valid=%b sum=%0d cnt=%0d trunc=%b ovf=%b required 1/256/256/1/0",
                     got, s, c, t, o);
        end
        $display("forced close: sum=%0d cnt=%0d trunc=%b", s, c, t);
        send_beat(16'd7, 1'b1);
        collect1(got, s, c, t, o);
        total++;
        if ({got, s, c, t, o} !== {1'b1, 24'd7, 9'd1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL after_forced_close: valid=%b sum=%0d cnt=%0d trunc=%b ovf=%b required 1/7/1/0/0",
                     got, s, c, t, o);
        end
        for (int i = 0; i < 255; i++) send_beat(16'h0002, 1'b0);
        send_beat(16'h0002, 1'b1);
        collect1(got, s, c, t, o);
        total++;
        if ({got, s, c, t, o} !== {1'b1, 24'd512, 9'd256, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL last_on_max: valid=%b sum=%0d cnt=%0d trunc=%b ovf=%b required 1/512/256/0/0",
                     got, s, c, t, o);
        end
        $display("last on 256th beat: sum=%0d trunc=%b", s, t);
    endtask

    task automatic test_overflow();
        logic got, t, o;
        logic [16:0] s;
        logic [16:0] exp_s;
        logic [8:0]  c;
`ifdef APPROX_MAC_SATURATE_EN
        exp_s = 17'h1FFFF;
`else
        exp_s = 17'h00002;
`endif
        send_beat2(16'hFFFF, 1'b0);
        send_beat2(16'hFFFF, 1'b0);
        send_beat2(16'h0004, 1'b1);
        collect2(got, s, c, t, o);
        total++;
        if ({got, s, c, t, o} !== {1'b1, exp_s, 9'd3, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL overflow: valid=%b sum=%h cnt=%0d trunc=%b ovf=%b required 1/%h/3/0/1",
                     got, s, c, t, o, exp_s);
        end
        $display("overflow frame: sum=%h ovf=%b", s, o);
        send_beat2(16'h0003, 1'b1);
        collect2(got, s, c, t, o);
        total++;
        if ({got, s, c, t, o} !== {1'b1, 17'd3, 9'd1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL ovf_cleared: valid=%b sum=%h cnt=%0d ovf=%b required 1/3/1/0",
                     got, s, c, o);
        end
        $display("frame after overflow: sum=%h ovf=%b", s, o);
    endtask

    task automatic test_gapped();
        logic got, t, o;
        logic [23:0] s;
        logic [8:0]  c;
        int gaps [4] = '{2, 0, 3, 1};
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gaps[i]; g++) @(negedge clk);
            send_beat(16'h0010, (i == 3) ? 1'b1 : 1'b0);
        end
        collect1(got, s, c, t, o);
        total++;
        if ({got, s, c, t, o} !== {1'b1, 24'h40, 9'd4, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL gapped: valid=%b sum=%h cnt=%0d trunc=%b ovf=%b required 1/40/4/0/0",
                     got, s, c, t, o);
        end
        $display("gapped frame: sum=%h cnt=%0d", s, c);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        b1.prod_valid = 1'b0; b1.prod_data = 16'h0; b1.prod_last = 1'b0; b1.out_ready = 1'b0;
        b2.prod_valid = 1'b0; b2.prod_data = 16'h0; b2.prod_last = 1'b0; b2.out_ready = 1'b0;
        test_reset();
        test_normal_frame();
        test_backpressure();
        test_forced_close();
        test_overflow();
        test_gapped();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
